// File: rtl/profile_dump_engine_if.sv
// Bus bundle for the profiling dump engine.
// Carries the dump request/status strobes, the SPSR arbitration and access path,
// and the 32-bit valid/ready output stream.
// Modports:
//   master - the dump engine (drives SPSR requests, writes and the stream)
//   slave  - the environment (arbiter, SPSR register file, stream sink)
interface profile_dump_if;
  logic        dumpRequest;
  logic        spsrRequest;
  logic        spsrGrant;
  logic        weSpsr;
  logic [15:0] spsrWriteIndex;
  logic [31:0] dataFromCore;
  logic [15:0] spsrReadIndex;
  logic [31:0] dataToCore;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [4:0]  outOffset;
  logic        outLast;
  logic        busy;
  logic        dumpDone;
  logic        requestDropped;

  modport master (
    input  dumpRequest, spsrGrant, dataToCore, outReady,
    output spsrRequest, weSpsr, spsrWriteIndex, dataFromCore, spsrReadIndex,
           outValid, outData, outOffset, outLast, busy, dumpDone, requestDropped
  );

  modport slave (
    output dumpRequest, spsrGrant, dataToCore, outReady,
    input  spsrRequest, weSpsr, spsrWriteIndex, dataFromCore, spsrReadIndex,
           outValid, outData, outOffset, outLast, busy, dumpDone, requestDropped
  );
endinterface

// File: rtl/profile_dump_engine.sv
// Profiling counter dump engine.
// On a dump request it takes the SPSR path through the arbiter, reads the
// profiling status word, optionally pauses the counters, reads every word from
// FIRST_OFFSET to LAST_OFFSET and streams them out on a valid/ready channel,
// then restores the original control bits.
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   bus          - profile_dump_if.master: request/grant, SPSR read/write path,
//                  output stream and status (busy, dumpDone, requestDropped)
module profile_dump_engine #(
  parameter logic [15:0] BASE_INDEX        = 16'hF800,
  parameter logic [4:0]  FIRST_OFFSET      = 5'd0,
  parameter logic [4:0]  LAST_OFFSET       = 5'd28,
  parameter bit          PAUSE_DURING_DUMP = 1'b1
) (
  input logic           clock,
  input logic           reset,
  profile_dump_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_STATUS, S_PAUSE, S_READ, S_EMIT, S_RESTORE, S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_offset;
  logic        r_saved_enable;
  logic        r_saved_pause;
  logic        r_pause_applied;
  logic        r_spsr_request;
  logic        r_we;
  logic [31:0] r_write_data;
  logic [15:0] r_read_index;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_offset;
  logic        r_out_last;
  logic        r_busy;
  logic        r_dump_done;
  logic        r_request_dropped;

  wire w_grant  = bus.spsrGrant;
  wire w_accept = r_out_valid & bus.outReady;

  function automatic logic [15:0] read_index(input logic [4:0] off);
    return BASE_INDEX + {11'd0, off};
  endfunction

  // Sequencer: arbitration, status capture, pause/restore writes and the word stream.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_offset          <= FIRST_OFFSET;
      r_saved_enable    <= 1'b0;
      r_saved_pause     <= 1'b0;
      r_pause_applied   <= 1'b0;
      r_spsr_request    <= 1'b0;
      r_we              <= 1'b0;
      r_write_data      <= 32'd0;
      r_read_index      <= BASE_INDEX;
      r_out_valid       <= 1'b0;
      r_out_data        <= 32'd0;
      r_out_offset      <= 5'd0;
      r_out_last        <= 1'b0;
      r_busy            <= 1'b0;
      r_dump_done       <= 1'b0;
      r_request_dropped <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      if (bus.dumpRequest && (r_state != S_IDLE)) begin
        r_request_dropped <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.dumpRequest) begin
            r_state           <= S_ARB;
            r_busy            <= 1'b1;
            r_spsr_request    <= 1'b1;
            r_request_dropped <= 1'b0;
          end
        end
        S_ARB: begin
          if (w_grant) begin
            r_read_index <= BASE_INDEX;
            r_state      <= S_STATUS;
          end
        end
        S_STATUS: begin
          if (w_grant) begin
            r_saved_enable <= bus.dataToCore[9];
            r_saved_pause  <= bus.dataToCore[10];
            r_offset       <= FIRST_OFFSET;
            r_read_index   <= read_index(FIRST_OFFSET);
            if (PAUSE_DURING_DUMP && bus.dataToCore[9] && !bus.dataToCore[10]) begin
              // Enable stays 1 in the pause write so the counters are not cleared.
              r_we            <= 1'b1;
              r_write_data    <= {21'd0, 1'b1, 1'b1, 9'd0};
              r_pause_applied <= 1'b1;
              r_state         <= S_PAUSE;
            end else begin
              r_pause_applied <= 1'b0;
              r_state         <= S_READ;
            end
          end
        end
        S_PAUSE: begin
          if (w_grant) begin
            r_we    <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Read index was set on entry, so dataToCore has settled for this offset.
          if (w_grant) begin
            r_out_data   <= bus.dataToCore;
            r_out_valid  <= 1'b1;
            r_out_offset <= r_offset;
            r_out_last   <= (r_offset == LAST_OFFSET);
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          // The word is already captured, so the sink may take it even while the
          // grant is withdrawn; the next SPSR step then waits for the grant.
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              if (r_pause_applied) begin
                r_we         <= 1'b1;
                r_write_data <= {21'd0, r_saved_pause, r_saved_enable, 9'd0};
                r_state      <= S_RESTORE;
              end else begin
                r_dump_done    <= 1'b1;
                r_spsr_request <= 1'b0;
                r_busy         <= 1'b0;
                r_state        <= S_DONE;
              end
            end else begin
              r_offset     <= r_offset + 5'd1;
              r_read_index <= read_index(r_offset + 5'd1);
              r_state      <= S_READ;
            end
          end
        end
        S_RESTORE: begin
          if (w_grant) begin
            r_we           <= 1'b0;
            r_dump_done    <= 1'b1;
            r_spsr_request <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is qualified by the grant so a withdrawn grant can never
  // see a write, even in the cycle the arbiter pulls it.
  assign bus.weSpsr         = r_we & w_grant;
  // Only the control/status word is ever written.
  assign bus.spsrWriteIndex = BASE_INDEX;
  assign bus.dataFromCore   = r_write_data;
  assign bus.spsrReadIndex  = r_read_index;
  assign bus.spsrRequest    = r_spsr_request;
  assign bus.outValid       = r_out_valid;
  assign bus.outData        = r_out_data;
  assign bus.outOffset      = r_out_offset;
  assign bus.outLast        = r_out_last;
  assign bus.busy           = r_busy;
  assign bus.dumpDone       = r_dump_done;
  assign bus.requestDropped = r_request_dropped;

endmodule

// File: tb/tb_profile_dump_engine.sv
// Self-checking bench for profile_dump_engine: an SPSR register file with free-
// running 64-bit counters, an arbiter and a stream sink around the engine, with
// a stream/write expectation model checked every cycle.
module tb_profile_dump_engine;
  localparam logic [15:0] BASE = 16'hF800;
  localparam int NWORDS = 29;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  profile_dump_if bus();
  profile_dump_engine dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // SPSR register file model: status/control word, 4 masks, 12 counters.
  logic [31:0] ctrl;
  logic [63:0] cnt [12];
  logic        tb_load = 1'b0;
  logic [31:0] tb_ctrl;
  logic [63:0] tb_seed [12];
  logic [15:0] rd_off;
  logic [31:0] rd_data;

  function automatic logic [31:0] word_at(input int off);
    int k;
    if (off == 0) return ctrl;
    if (off <= 4) return 32'hA5A5_0000 | 32'(off);
    k = (off - 5) / 2;
    if (((off - 5) % 2) == 0) return cnt[k][31:0];
    return cnt[k][63:32];
  endfunction

  always_comb begin
    rd_off  = bus.spsrReadIndex - BASE;
    rd_data = 32'hDEAD_BEEF;
    if (rd_off < 16'd29) rd_data = word_at(int'(rd_off));
  end
  assign bus.dataToCore = rd_data;

  // Counters run while enabled and not paused; writes change control bits 10:9.
  always @(posedge clock) begin
    if (tb_load) begin
      ctrl <= tb_ctrl;
      for (int i = 0; i < 12; i++) cnt[i] <= tb_seed[i];
    end else begin
      if (ctrl[9] && !ctrl[10]) begin
        for (int i = 0; i < 12; i++) cnt[i] <= cnt[i] + 64'(i + 1);
      end
      if (bus.weSpsr && bus.spsrGrant && bus.spsrWriteIndex == BASE) begin
        ctrl <= {ctrl[31:11], bus.dataFromCore[10:9], ctrl[8:0]};
      end
    end
  end

  // Arbiter and sink.
  logic grant_block = 1'b0;
  int   ready_mode = 0;
  int   ready_cnt = 0;
  always @(posedge clock) begin
    #1;
    bus.spsrGrant = bus.spsrRequest && !grant_block;
    ready_cnt++;
    case (ready_mode)
      0: bus.outReady = 1'b1;
      1: bus.outReady = ((ready_cnt % 3) == 0);
      default: bus.outReady = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input string req);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=%s", name, act, req);
  endtask

  // Expectation model state.
  bit          m_busy = 1'b0;
  bit          m_dropped = 1'b0;
  int          m_next_off = 0;
  logic [31:0] snap [NWORDS];
  bit          snap_valid = 1'b0;
  bit          wait_pause = 1'b0;
  bit          snap_next = 1'b0;
  logic [31:0] exp_writes [$];
  bit          prev_reset = 1'b0;
  bit          prev_stall = 1'b0;
  logic [37:0] prev_word;
  logic [31:0] rec_status, rec_first, rec_last;
  int          rec_writes = 0;
  bit          lit_check = 1'b0;
  logic [31:0] lit_status, lit_first, lit_last;
  int          lit_nwrites;

  task automatic take_snapshot();
    for (int o = 0; o < NWORDS; o++) snap[o] = word_at(o);
    snap_valid = 1'b1;
  endtask

  // Compare process, sampled on the falling edge.
  always @(negedge clock) begin
    if (prev_reset) begin
      chk("reset_flags", 64'({bus.busy, bus.spsrRequest, bus.weSpsr, bus.outValid,
                              bus.outLast, bus.dumpDone, bus.requestDropped}), 64'd0);
      chk("reset_outdata", 64'({bus.outData, bus.outOffset}), 64'd0);
      chk("reset_indices", 64'({bus.spsrWriteIndex, bus.spsrReadIndex}), 64'({BASE, BASE}));
      chk("reset_wdata", 64'(bus.dataFromCore), 64'd0);
    end
    if (reset) begin
      prev_reset = 1'b1;
      prev_stall = 1'b0;
      m_busy = 1'b0;
      m_dropped = 1'b0;
      m_next_off = 0;
      snap_valid = 1'b0;
      wait_pause = 1'b0;
      snap_next = 1'b0;
      exp_writes.delete();
    end else begin
      prev_reset = 1'b0;
      if (snap_next) begin
        take_snapshot();
        snap_next = 1'b0;
      end
      if (!bus.spsrGrant) chk("we_without_grant", 64'(bus.weSpsr), 64'd0);
      if (bus.weSpsr) begin
        chk("write_index", 64'(bus.spsrWriteIndex), 64'(BASE));
        if (exp_writes.size() == 0) begin
          fail("unexpected_write", 64'(bus.dataFromCore), "no write");
        end else begin
          chk("write_data", 64'(bus.dataFromCore), 64'(exp_writes.pop_front()));
          rec_writes++;
          if (rec_writes == 1) rec_first = bus.dataFromCore;
          rec_last = bus.dataFromCore;
          if (wait_pause) begin
            wait_pause = 1'b0;
            snap_next = 1'b1;
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.outValid), 64'd1);
        chk("stall_word", 64'({bus.outData, bus.outOffset, bus.outLast}), 64'(prev_word));
      end
      if (bus.outValid && !snap_valid) fail("word_before_snapshot", 64'(bus.outOffset), "no word");
      if (bus.outValid && bus.outReady && snap_valid) begin
        if (m_next_off >= NWORDS) begin
          fail("extra_word", 64'(bus.outOffset), "none after 28");
        end else begin
          chk("word_offset", 64'(bus.outOffset), 64'(m_next_off));
          chk("word_data", 64'(bus.outData), 64'(snap[m_next_off]));
          chk("word_last", 64'(bus.outLast), 64'(m_next_off == NWORDS - 1));
          if (m_next_off == 0) rec_status = bus.outData;
          m_next_off++;
        end
      end
      prev_stall = bus.outValid && !bus.outReady;
      prev_word = {bus.outData, bus.outOffset, bus.outLast};
      chk("requestDropped", 64'(bus.requestDropped), 64'(m_dropped));
      if (bus.dumpDone) begin
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_words", 64'(m_next_off), 64'(NWORDS));
        chk("done_writes_left", 64'(exp_writes.size()), 64'd0);
        if (lit_check) begin
          chk("lit_status_word", 64'(rec_status), 64'(lit_status));
          chk("lit_nwrites", 64'(rec_writes), 64'(lit_nwrites));
          if (lit_nwrites > 0) begin
            chk("lit_pause_write", 64'(rec_first), 64'(lit_first));
            chk("lit_restore_write", 64'(rec_last), 64'(lit_last));
          end
        end
        m_busy = 1'b0;
        snap_valid = 1'b0;
        m_next_off = 0;
      end else begin
        chk("busy", 64'(bus.busy), 64'(m_busy));
      end
      if (bus.dumpRequest) begin
        if (m_busy) begin
          m_dropped = 1'b1;
        end else begin
          m_dropped = 1'b0;
          m_busy = 1'b1;
          rec_writes = 0;
          if (ctrl[9] && !ctrl[10]) begin
            exp_writes.push_back(32'h0000_0600);
            exp_writes.push_back({21'd0, ctrl[10], ctrl[9], 9'd0});
            wait_pause = 1'b1;
          end else begin
            take_snapshot();
          end
        end
      end
    end
  end

  // Stimulus tasks: entered and left at posedge+1.
  task automatic load(input logic [31:0] v);
    tb_ctrl = v;
    for (int i = 0; i < 12; i++) begin
      tb_seed[i] = {$urandom, ((i % 2) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom};
    end
    tb_load = 1'b1;
    @(posedge clock); #1;
    tb_load = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic pulse_request();
    bus.dumpRequest = 1'b1;
    @(posedge clock); #1;
    bus.dumpRequest = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.dumpDone && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 3000) fail("timeout_done", 64'(n), "dumpDone");
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_offset(input logic [4:0] off);
    int n = 0;
    while (!(bus.outValid && bus.outOffset == off) && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 3000) fail("timeout_offset", 64'(off), "offset seen");
  endtask

  task automatic set_lits(input logic [31:0] st, input int nw);
    lit_check = 1'b1;
    lit_status = st;
    lit_nwrites = nw;
    lit_first = 32'h0000_0600;
    lit_last = 32'h0000_0200;
  endtask

  initial begin
    logic [31:0] pick [4];
    pick[0] = 32'h0001_02FF;
    pick[1] = 32'h0000_01FF;
    pick[2] = 32'h0000_06FF;
    pick[3] = 32'h0000_04FF;
    reset = 1'b1;
    bus.dumpRequest = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Enabled, unpaused, sink always ready.
    load(32'h0001_02FF);
    set_lits(32'h0001_06FF, 2);
    pulse_request();
    wait_done();

    // Profiling disabled: no control writes.
    load(32'h0000_01FF);
    set_lits(32'h0000_01FF, 0);
    pulse_request();
    wait_done();

    // Sink ready one cycle in three while counters would be running.
    ready_mode = 1;
    load(32'h0001_02FF);
    set_lits(32'h0001_06FF, 2);
    pulse_request();
    wait_done();

    // Grant withheld for 10 cycles, then dropped for 5 cycles mid-stream.
    ready_mode = 0;
    load(32'h0001_02FF);
    grant_block = 1'b1;
    pulse_request();
    repeat (10) @(posedge clock);
    #1 grant_block = 1'b0;
    wait_offset(5'd5);
    grant_block = 1'b1;
    repeat (5) @(posedge clock);
    #1 grant_block = 1'b0;
    wait_done();

    // Second request during the dump is dropped and flagged until the next accept.
    load(32'h0001_02FF);
    pulse_request();
    wait_offset(5'd7);
    pulse_request();
    wait_done();
    chk("dropped_sticky", 64'(bus.requestDropped), 64'd1);
    lit_check = 1'b0;
    load(32'h0000_01FF);
    pulse_request();
    @(posedge clock); #1;
    chk("dropped_cleared", 64'(bus.requestDropped), 64'd0);
    wait_done();

    // Reset in the middle of the stream: no restore write follows.
    load(32'h0001_02FF);
    pulse_request();
    wait_offset(5'd12);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_reset_busy", 64'(bus.busy), 64'd0);
    chk("mid_reset_valid", 64'(bus.outValid), 64'd0);
    repeat (10) @(posedge clock);
    #1;

    // Request and reset together: reset wins.
    bus.dumpRequest = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    bus.dumpRequest = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("req_with_reset_busy", 64'(bus.busy), 64'd0);

    // Randomized dumps: random status words, random sink, random grant glitches.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) load(pick[t]);
      else load($urandom);
      pulse_request();
      repeat ($urandom_range(5, 60)) @(posedge clock);
      #1 grant_block = 1'b1;
      repeat ($urandom_range(1, 6)) @(posedge clock);
      #1 grant_block = 1'b0;
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
